// File: rtl/sweep_scheduler.sv
// Frequency-sweep sequencer: steps the NCO table address, settles, averages 2^AVG_LOG2 measurements per point.
// Optional macro SWEEP_TIMEOUT_EN adds a meas_done timeout in WAIT and drives res_timeout.
module sweep_scheduler #(
   parameter int ADDR_WIDTH     = 8,
   parameter int N_POINTS       = 200,
   parameter int SETTLE_CYCLES  = 1024,
   parameter int AVG_LOG2       = 2,
   parameter int RESULT_WIDTH   = 32,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                           clk125,
   input  logic                           sreset,
   input  logic                           start,
   input  logic                           abort,
   output logic                           busy,
   output logic                           done,
   output logic [ADDR_WIDTH-1:0]          freq_addr,
   input  logic                           nco_valid,
   output logic                           meas_start,
   input  logic                           meas_done,
   input  logic signed [RESULT_WIDTH-1:0] meas_modulo,
   input  logic signed [RESULT_WIDTH-1:0] meas_phase,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [ADDR_WIDTH-1:0]          res_addr,
   output logic signed [RESULT_WIDTH-1:0] res_modulo,
   output logic signed [RESULT_WIDTH-1:0] res_phase,
   output logic                           res_timeout
);
   localparam int ACC_W  = RESULT_WIDTH + AVG_LOG2;
   localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam int NCNT_W = AVG_LOG2 + 1;
   localparam logic [NCNT_W-1:0]     N_AVG     = NCNT_W'(1 << AVG_LOG2);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_POINTS - 1);

   if (N_POINTS < 1 || N_POINTS > (1 << ADDR_WIDTH) || SETTLE_CYCLES < 1 ||
       AVG_LOG2 < 0 || AVG_LOG2 > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("sweep_scheduler: parameter out of range");
   end

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_MEAS, S_WAIT, S_OUTPUT, S_NEXT} state_t;

   state_t                    state_q;
   logic                      busy_q, done_q, meas_start_q, res_valid_q, nco_low_q;
   logic [ADDR_WIDTH-1:0]     freq_addr_q, res_addr_q;
   logic signed [RESULT_WIDTH-1:0] res_mod_q, res_ph_q;
   logic signed [ACC_W-1:0]   acc_mod_q, acc_ph_q;
   logic [NCNT_W-1:0]         nsamp_q;
   logic [SCNT_W-1:0]         settle_cnt_q;

   logic signed [ACC_W-1:0]   smp_mod_d, smp_ph_d, acc_mod_d, acc_ph_d;
   logic [NCNT_W-1:0]         nsamp_d;
   logic                      take_d;
   logic                      last_pt;

`ifdef SWEEP_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TCNT_W-1:0]         tmo_cnt_q;
   logic                      tmo_flag_q, res_tmo_q, tmo_hit_d;
`endif

   function automatic logic signed [RESULT_WIDTH-1:0] avg_of(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sh;
      sh = acc >>> AVG_LOG2;
      return sh[RESULT_WIDTH-1:0];
   endfunction

   assign last_pt = (freq_addr_q == LAST_ADDR);

   always_comb begin
      smp_mod_d = ACC_W'(meas_modulo);
      smp_ph_d  = ACC_W'(meas_phase);
      take_d    = (state_q == S_WAIT) && meas_done;
`ifdef SWEEP_TIMEOUT_EN
      tmo_hit_d = 1'b0;
      // A timed-out measurement still counts as a sample, contributing zero.
      if (state_q == S_WAIT && !meas_done && tmo_cnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
         tmo_hit_d = 1'b1;
         take_d    = 1'b1;
         smp_mod_d = '0;
         smp_ph_d  = '0;
      end
`endif
      acc_mod_d = acc_mod_q + smp_mod_d;
      acc_ph_d  = acc_ph_q + smp_ph_d;
      nsamp_d   = nsamp_q + NCNT_W'(1);
   end

   always_ff @(posedge clk125) begin
      // abort behaves like reset: everything returns to the idle state with no done pulse.
      if (sreset || abort) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         freq_addr_q  <= '0;
         meas_start_q <= 1'b0;
         res_valid_q  <= 1'b0;
         res_addr_q   <= '0;
         res_mod_q    <= '0;
         res_ph_q     <= '0;
         acc_mod_q    <= '0;
         acc_ph_q     <= '0;
         nsamp_q      <= '0;
         settle_cnt_q <= '0;
         nco_low_q    <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         tmo_flag_q   <= 1'b0;
         res_tmo_q    <= 1'b0;
`endif
      end else begin
         done_q       <= 1'b0;
         meas_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q     <= S_LOAD;
                  busy_q      <= 1'b1;
                  freq_addr_q <= '0;
                  nco_low_q   <= 1'b0;
               end
            end
            S_LOAD: begin
               // Require a low-then-high on nco_valid so a stale valid is never trusted.
               if (!nco_valid) begin
                  nco_low_q <= 1'b1;
               end else if (nco_low_q) begin
                  state_q      <= S_SETTLE;
                  settle_cnt_q <= '0;
               end
            end
            S_SETTLE: begin
               if (settle_cnt_q == SCNT_W'(SETTLE_CYCLES - 1)) begin
                  state_q      <= S_MEAS;
                  meas_start_q <= 1'b1;
               end else begin
                  settle_cnt_q <= settle_cnt_q + SCNT_W'(1);
               end
            end
            S_MEAS: begin
               state_q <= S_WAIT;
`ifdef SWEEP_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
            end
            S_WAIT: begin
`ifdef SWEEP_TIMEOUT_EN
               tmo_cnt_q <= take_d ? '0 : tmo_cnt_q + TCNT_W'(1);
               if (tmo_hit_d) tmo_flag_q <= 1'b1;
               res_tmo_q <= tmo_flag_q | tmo_hit_d;
`endif
               if (take_d) begin
                  acc_mod_q <= acc_mod_d;
                  acc_ph_q  <= acc_ph_d;
                  nsamp_q   <= nsamp_d;
                  if (nsamp_d == N_AVG) begin
                     state_q     <= S_OUTPUT;
                     res_valid_q <= 1'b1;
                     res_addr_q  <= freq_addr_q;
                     res_mod_q   <= avg_of(acc_mod_d);
                     res_ph_q    <= avg_of(acc_ph_d);
                  end else begin
                     state_q      <= S_MEAS;
                     meas_start_q <= 1'b1;
                  end
               end
            end
            S_OUTPUT: begin
               if (res_ready) begin
                  state_q     <= S_NEXT;
                  res_valid_q <= 1'b0;
                  if (last_pt) begin
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                  end
               end
            end
            S_NEXT: begin
               acc_mod_q <= '0;
               acc_ph_q  <= '0;
               nsamp_q   <= '0;
               nco_low_q <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
               tmo_flag_q <= 1'b0;
`endif
               if (last_pt) begin
                  freq_addr_q <= '0;
                  state_q     <= S_IDLE;
               end else begin
                  freq_addr_q <= freq_addr_q + ADDR_WIDTH'(1);
                  state_q     <= S_LOAD;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign freq_addr  = freq_addr_q;
   assign meas_start = meas_start_q;
   assign res_valid  = res_valid_q;
   assign res_addr   = res_addr_q;
   assign res_modulo = res_mod_q;
   assign res_phase  = res_ph_q;
`ifdef SWEEP_TIMEOUT_EN
   assign res_timeout = res_tmo_q;
`else
   assign res_timeout = 1'b0;
`endif
endmodule

// File: doc/sweep_scheduler.md
Name: sweep_scheduler

Overview:
- Sequences a full frequency sweep: steps the phase-increment table address, waits for the NCO output to become valid, then waits a settle time.
- Launches the zero-cross measurement engine 2^AVG_LOG2 times per point and averages the MODULO/PHASE results.
- Emits one averaged result per point over a valid/ready stream.
- Sits between the top-level start/control logic and the NCO + measurement datapath, in the clk125 domain.

Parameters:
ADDR_WIDTH, 8, width of frequency table address
N_POINTS, 200, number of sweep points (1..2^ADDR_WIDTH)
SETTLE_CYCLES, 1024, clk125 cycles waited after nco_valid before first measurement (>=1)
AVG_LOG2, 2, log2 of measurements averaged per point (0..4)
RESULT_WIDTH, 32, width of signed modulo/phase values
TIMEOUT_CYCLES, 65535, meas_done timeout (used only with SWEEP_TIMEOUT_EN)

Ports:
clk125  in  1  system clock
sreset  in  1  synchronous active-high reset
start  in  1  begin sweep (sampled in IDLE only)
abort  in  1  terminate sweep, return to IDLE
busy  out  1  high from sweep launch until done/abort
done  out  1  one-cycle pulse after last point result accepted
freq_addr  out  ADDR_WIDTH  frequency table address driven to ROM
nco_valid  in  1  NCO out_valid
meas_start  out  1  one-cycle pulse launching one measurement
meas_done  in  1  one-cycle pulse, measurement complete
meas_modulo  in  RESULT_WIDTH  signed modulo from engine, valid with meas_done
meas_phase  in  RESULT_WIDTH  signed phase from engine, valid with meas_done
res_valid  out  1  averaged result available
res_ready  in  1  consumer accepts result
res_addr  out  ADDR_WIDTH  point index of result
res_modulo  out  RESULT_WIDTH  averaged modulo
res_phase  out  RESULT_WIDTH  averaged phase
res_timeout  out  1  point contained a timed-out measurement

Behaviour:
- Clock, reset: one clock, clk125; reset is synchronous and active-high (sreset).
- Reset values: all outputs 0, state IDLE, accumulators 0, counters 0.
- IDLE:
  - start=1 -> LOAD next cycle; busy=1, freq_addr=0.
  - start is ignored in any other state.
- LOAD:
  - Entered with freq_addr already updated.
  - nco_valid must be seen low at least once, then high, before moving to SETTLE. This prevents using a stale valid from the previous increment.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then MEAS.
- MEAS:
  - meas_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - meas_done is sampled only in WAIT, so a done pulse coinciding with meas_start is ignored.
  - On meas_done: meas_modulo and meas_phase are sign-extended to RESULT_WIDTH+AVG_LOG2 and added to the accumulators; the sample counter increments.
  - If the sample counter < 2^AVG_LOG2, go to MEAS next cycle (no re-settle).
  - Otherwise go to OUTPUT.
- OUTPUT:
  - res_modulo = acc_mod >>> AVG_LOG2 and res_phase = acc_ph >>> AVG_LOG2 (arithmetic shift; truncation toward -inf).
  - res_addr = freq_addr; res_valid=1.
  - Outputs are held stable until res_ready=1. The handshake completes on a cycle with res_valid&&res_ready.
  - Back-pressure stalls the sweep indefinitely.
- NEXT:
  - Taken after acceptance; clears accumulators and sample counter.
  - If freq_addr==N_POINTS-1: freq_addr=0, busy=0, done=1 for one cycle, state IDLE.
  - Otherwise freq_addr+1, state LOAD.
- Latency: a result is presented 1 cycle after the final meas_done. done is asserted 1 cycle after the last handshake.
- abort=1 in any state:
  - Next cycle the state is IDLE with busy=0, res_valid=0, meas_start=0, freq_addr=0, accumulators cleared; no done pulse.
  - abort has priority over start, meas_done and the handshake in the same cycle.
- sreset mid-sweep: identical to the reset state; a pending result is dropped.

Optional Feature:
- Macro: SWEEP_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT. If TIMEOUT_CYCLES elapse without meas_done, the measurement counts as a sample contributing 0 to both accumulators, and a sticky per-point flag is set.
  - Flow continues as for meas_done; res_timeout presents the flag with the result, and the flag is cleared in NEXT.
  - A meas_done arriving on the timeout cycle wins: its data is used and no timeout occurs.
- Undefined: no counter; WAIT waits indefinitely; res_timeout tied 0.

Test Plan:
- N_POINTS=3, AVG_LOG2=2, SETTLE_CYCLES=4, res_ready=1; engine returns modulo 100,104,96,100 and phase -10,-12,-8,-10 -> three results, each res_modulo=100 and res_phase=-10, res_addr=0,1,2, done pulse once, busy low afterwards.
- Averaging truncation: samples modulo -1,-1,-1,-2 -> res_modulo = -5>>>2 = -2.
- Back-pressure: res_ready low for 50 cycles on point 1 -> res_valid and data stable for all 50 cycles, no meas_start issued, freq_addr stays 1.
- abort asserted in WAIT of point 1, coincident with meas_done -> IDLE next cycle, busy=0, no result, no done; a new start restarts at freq_addr=0.
- nco_valid held high through LOAD -> no SETTLE until nco_valid toggles low then high; a meas_done pulse injected during SETTLE -> ignored.
- With SWEEP_TIMEOUT_EN, TIMEOUT_CYCLES=100: second measurement never completes -> after 100 cycles the sweep continues; with other samples 200,200,200, res_modulo=150 and res_timeout=1; the next point has res_timeout=0.
